// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep sequencer.
//   SWEEP_WIDTH   : default counter / bound width
//   SWEEP_PASS_W  : default width of the pass-count field
//   sweep_state_e : sequencer state encoding
package sweep_pkg;

  localparam int unsigned SWEEP_WIDTH  = 8;
  localparam int unsigned SWEEP_PASS_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SEEK  = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4,
    DONE  = 3'd5
  } sweep_state_e;

endpackage

// File: rtl/updown_counter.sv
// Plain up/down counter driven by the sweep sequencer.
//   clk_i     : rising-edge clock
//   rst_i     : synchronous active-high clear
//   enable_i  : count this cycle
//   dir_i     : 1 = increment, 0 = decrement
//   value_o   : registered count
module updown_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (enable_i) begin
      value_q <= dir_i ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: takes a (lo, hi, passes) command and steers an external
// up/down counter so that its value traces lo->hi->lo triangles for the
// requested number of passes, then pulses done.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, so commands
// presented at any other time are simply not taken.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_lo/cmd_hi       : sweep bounds (unsigned, lo <= hi required)
//   cmd_passes          : number of full passes (0 is rejected)
//   abort               : stop the active sweep, counter holds its value
//   ctr_value           : registered counter output fed back
//   ctr_rst/ctr_enable/ctr_direction : counter controls (combinational)
//   busy                : sequencer not in IDLE
//   done / err          : one-cycle registered completion / reject pulses
//   pass_cnt            : passes completed in the current / last sweep
//   dbg_state_o         : current state, for observation only
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH  = SWEEP_WIDTH,
  parameter int unsigned PASS_W = SWEEP_PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_lo,
  input  logic [WIDTH-1:0]  cmd_hi,
  input  logic [PASS_W-1:0] cmd_passes,
  input  logic              abort,
  input  logic [WIDTH-1:0]  ctr_value,
  output logic              ctr_rst,
  output logic              ctr_enable,
  output logic              ctr_direction,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt,
  output sweep_state_e      dbg_state_o
);

  sweep_state_e      state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [PASS_W-1:0] rem_q, rem_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    rem_d         = rem_q;
    pass_cnt_d    = pass_cnt_q;
    err_d         = 1'b0;
    ctr_rst       = 1'b0;
    ctr_enable    = 1'b0;
    ctr_direction = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if ((cmd_lo > cmd_hi) || (cmd_passes == '0)) begin
            err_d = 1'b1;
          end else begin
            lo_d       = cmd_lo;
            hi_d       = cmd_hi;
            rem_d      = cmd_passes;
            pass_cnt_d = '0;
            state_d    = CLEAR;
          end
        end
      end

      CLEAR: begin
        ctr_rst = 1'b1;
        state_d = SEEK;
      end

      // Climb from 0 to lo; the cycle that sees lo is a hold cycle.
      SEEK: begin
        if (ctr_value != lo_q) begin
          ctr_enable    = 1'b1;
          ctr_direction = 1'b1;
        end else begin
          state_d = UP;
        end
      end

      UP: begin
        if (lo_q == hi_q) begin
          // Degenerate sweep: every cycle here completes one pass with
          // the counter parked at lo.
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          rem_d      = rem_q - PASS_W'(1);
          state_d    = (rem_q > PASS_W'(1)) ? UP : DONE;
        end else if (ctr_value != hi_q) begin
          ctr_enable    = 1'b1;
          ctr_direction = 1'b1;
        end else begin
          // Turn around immediately so hi is visited for one cycle only.
          ctr_enable    = 1'b1;
          ctr_direction = 1'b0;
          state_d       = DOWN;
        end
      end

      DOWN: begin
        if (ctr_value != lo_q) begin
          ctr_enable    = 1'b1;
          ctr_direction = 1'b0;
        end else begin
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          rem_d      = rem_q - PASS_W'(1);
          if (rem_q > PASS_W'(1)) begin
            ctr_enable    = 1'b1;
            ctr_direction = 1'b1;
            state_d       = UP;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything outside IDLE: freeze the counter and keep
    // whatever partial pass count has accumulated.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      rem_d         = rem_q;
      pass_cnt_d    = pass_cnt_q;
      ctr_rst       = 1'b0;
      ctr_enable    = 1'b0;
      ctr_direction = 1'b0;
    end

    // DONE is always left after one cycle, so this yields a single pulse.
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      rem_q      <= '0;
      pass_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      rem_q      <= rem_d;
      pass_cnt_q <= pass_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign pass_cnt    = pass_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl driving an updown_counter.
module tb_sweep_ctrl;
  import sweep_pkg::*;

  localparam int W = 8;
  localparam int P = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_lo     = '0;
  logic [W-1:0]  cmd_hi     = '0;
  logic [P-1:0]  cmd_passes = '0;
  logic          abort      = 1'b0;
  logic [W-1:0]  ctr_value;
  logic          ctr_rst, ctr_enable, ctr_direction;
  logic          busy, done, err;
  logic [P-1:0]  pass_cnt;
  sweep_state_e  dbg_state;

  sweep_ctrl #(.WIDTH(W), .PASS_W(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_passes(cmd_passes),
    .abort(abort), .ctr_value(ctr_value),
    .ctr_rst(ctr_rst), .ctr_enable(ctr_enable), .ctr_direction(ctr_direction),
    .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt),
    .dbg_state_o(dbg_state)
  );

  updown_counter #(.WIDTH(W)) u_ctr (
    .clk_i(clk), .rst_i(ctr_rst), .enable_i(ctr_enable),
    .dir_i(ctr_direction), .value_o(ctr_value)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [P-1:0] passes);
    cmd_lo     = lo;
    cmd_hi     = hi;
    cmd_passes = passes;
    cmd_valid  = 1'b1;
    check("cmd_ready", 32'(cmd_ready), 1);
    step();
    cmd_valid  = 1'b0;
  endtask

  // One expected counter value per cycle, starting with the first SEEK cycle.
  task automatic run_trace(input string tag);
    logic [W-1:0] e;
    done_seen = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check(tag, 32'(ctr_value), 32'(e));
      if (done) done_seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int found;
    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",      32'(busy), 0);
    check("rst_ready",     32'(cmd_ready), 1);
    check("rst_done",      32'(done), 0);
    check("rst_err",       32'(err), 0);
    check("rst_ctr_rst",   32'(ctr_rst), 0);
    check("rst_ctr_en",    32'(ctr_enable), 0);
    check("rst_ctr_dir",   32'(ctr_direction), 0);
    check("rst_pass_cnt",  32'(pass_cnt), 0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));
    step(); step();
    rst_n = 1'b1;
    step();

    // lo=3 hi=5 passes=2
    send_cmd(8'd3, 8'd5, 4'd2);
    check("t1_clear_rst", 32'(ctr_rst), 1);
    check("t1_busy", 32'(busy), 1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd4, 8'd5, 8'd4, 8'd3};
    run_trace("t1_trace");
    check("t1_no_early_done", 32'(done_seen), 0);
    step();
    check("t1_done", 32'(done), 1);
    check("t1_pass_cnt", 32'(pass_cnt), 2);
    check("t1_val_done", 32'(ctr_value), 3);
    step();
    check("t1_done_drop", 32'(done), 0);
    check("t1_idle", 32'(busy), 0);
    step();
    check("t1_hold", 32'(ctr_value), 3);

    // lo=0 hi=2 passes=1
    send_cmd(8'd0, 8'd2, 4'd1);
    step();
    check("t2_seek_val", 32'(ctr_value), 0);
    check("t2_seek_state", 32'(dbg_state), 32'(SEEK));
    step();
    check("t2_hold_val", 32'(ctr_value), 0);
    check("t2_up_state", 32'(dbg_state), 32'(UP));
    exp_q = '{8'd1, 8'd2, 8'd1, 8'd0};
    run_trace("t2_trace");
    step();
    check("t2_done", 32'(done), 1);
    check("t2_busy_in_done", 32'(busy), 1);
    check("t2_pass_cnt", 32'(pass_cnt), 1);
    step();
    check("t2_idle", 32'(busy), 0);

    // lo=hi=7 passes=3
    send_cmd(8'd7, 8'd7, 4'd3);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    run_trace("t3_seek");
    check("t3_seek_hold_en", 32'(ctr_enable), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_up_state", 32'(dbg_state), 32'(UP));
      check("t3_pass_step", 32'(pass_cnt), 32'(k));
      check("t3_en_off", 32'(ctr_enable), 0);
      check("t3_val", 32'(ctr_value), 7);
    end
    step();
    check("t3_done", 32'(done), 1);
    check("t3_pass_cnt", 32'(pass_cnt), 3);
    check("t3_en_done", 32'(ctr_enable), 0);
    step();
    check("t3_idle", 32'(busy), 0);

    // rejects
    cmd_lo = 8'd9; cmd_hi = 8'd4; cmd_passes = 4'd1; cmd_valid = 1'b1;
    check("r1_rst_idle", 32'(ctr_rst), 0);
    step();
    cmd_valid = 1'b0;
    check("r1_err", 32'(err), 1);
    check("r1_busy", 32'(busy), 0);
    check("r1_ctr_rst", 32'(ctr_rst), 0);
    step();
    check("r1_err_drop", 32'(err), 0);
    check("r1_busy2", 32'(busy), 0);
    cmd_lo = 8'd1; cmd_hi = 8'd2; cmd_passes = 4'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("r2_err", 32'(err), 1);
    check("r2_busy", 32'(busy), 0);
    step();

    // abort at first 150 on an up-slope
    send_cmd(8'd10, 8'd200, 4'd5);
    found = 0;
    done_seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (done) done_seen++;
      if (ctr_value == 8'd150) begin
        found = 1;
        break;
      end
    end
    check("t5_reach150", 32'(found), 1);
    check("t5_up_slope", 32'(ctr_direction), 1);
    abort = 1'b1;
    #1;
    check("t5_abort_en", 32'(ctr_enable), 0);
    step();
    abort = 1'b0;
    check("t5_idle", 32'(busy), 0);
    check("t5_frozen", 32'(ctr_value), 150);
    check("t5_no_done", 32'(done), 0);
    check("t5_pass_cnt", 32'(pass_cnt), 0);
    step();
    check("t5_frozen2", 32'(ctr_value), 150);
    check("t5_no_done_any", 32'(done_seen + int'(done)), 0);

    // async reset mid-DOWN, then a fresh sweep
    send_cmd(8'd3, 8'd5, 4'd2);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd5, 8'd4};
    run_trace("t6_trace");
    check("t6_in_down", 32'(dbg_state), 32'(DOWN));
    check("t6_en_down", 32'(ctr_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_en", 32'(ctr_enable), 0);
    check("t6_dir", 32'(ctr_direction), 0);
    check("t6_ctr_rst", 32'(ctr_rst), 0);
    check("t6_pass_cnt", 32'(pass_cnt), 0);
    step(); step();
    rst_n = 1'b1;
    check("t6_not_cleared", 32'(ctr_value), 4);
    step();
    send_cmd(8'd0, 8'd2, 4'd1);
    check("t6_clear", 32'(ctr_rst), 1);
    exp_q = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0};
    run_trace("t6_retrace");
    step();
    check("t6_done", 32'(done), 1);
    step();
    check("t6_idle", 32'(busy), 0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
